// File: rtl/disp_arbiter.sv
// disp_arbiter: four-way round-robin display arbiter with serial binary-to-BCD conversion.
// Optional leading-zero blanking is enabled by defining DISP_LZB_EN; the default build
// commits plain BCD digits.
module disp_arbiter #(
    parameter int unsigned DWELL_CYCLES = 100000000
) (
    input  logic        clk_100mhz,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [63:0] data_flat,
    output logic [3:0]  grant,
    output logic        busy,
    output logic [15:0] bcd,
    output logic [1:0]  src_id,
    output logic        overflow,
    output logic        bcd_valid
);

    localparam int unsigned DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [15:0] SAT_VAL = 16'd9999;
    localparam logic [4:0] LAST_ITER = 5'd16;

    typedef enum logic [1:0] {IDLE, CONVERT, SHOW} state_t;

    state_t        state_q;
    logic [1:0]    ptr_q;
    logic [15:0]   bin_q;
    logic [15:0]   acc_q;
    logic [4:0]    iter_q;
    logic          ovf_pend_q;
    logic [1:0]    src_pend_q;
    logic [DW-1:0] dwell_q;
    logic [3:0]    grant_q;
    logic          busy_q;
    logic [15:0]   bcd_q;
    logic [1:0]    src_q;
    logic          ovf_q;
    logic          valid_q;

    logic          sel_hit;
    logic [1:0]    sel_idx;
    logic [1:0]    cand_idx;
    logic [15:0]   sel_raw;
    logic [15:0]   sel_val;
    logic          sel_ovf;
    logic          launch;
    logic          dwell_done;
    logic [15:0]   acc_adj;
    logic [15:0]   acc_d;
    logic [15:0]   commit_bcd;

    // Round-robin pick: first requester at or after the pointer, searched modulo 4.
    always_comb begin
        sel_hit  = 1'b0;
        sel_idx  = ptr_q;
        cand_idx = '0;
        for (int k = 3; k >= 0; k--) begin
            cand_idx = ptr_q + 2'(k);
            if (req[cand_idx]) begin
                sel_hit = 1'b1;
                sel_idx = cand_idx;
            end
        end
    end

    // Capture value of the selected requester, saturated to the four-digit range.
    always_comb begin
        sel_raw = data_flat[{sel_idx, 4'b0000} +: 16];
        sel_ovf = (sel_raw > SAT_VAL);
        sel_val = sel_ovf ? SAT_VAL : sel_raw;
    end

    // The final dwell edge doubles as the idle arbitration point, so a held request
    // is re-granted with no dead cycle between passes.
    always_comb begin
        dwell_done = (state_q == SHOW) && (dwell_q == DWELL_LAST);
        launch     = sel_hit && ((state_q == IDLE) || dwell_done);
    end

    // One shift-add-3 step: correct digits >= 5, then shift in the next binary MSB.
    always_comb begin
        acc_adj = acc_q;
        for (int d = 0; d < 4; d++) begin
            if (acc_q[4*d +: 4] >= 4'd5) begin
                acc_adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
            end
        end
        acc_d = {acc_adj[14:0], bin_q[15]};
    end

`ifdef DISP_LZB_EN
    // Blank leading zero digits above the units digit.
    always_comb begin
        commit_bcd = acc_q;
        if (acc_q[15:12] == 4'd0) begin
            commit_bcd[15:12] = 4'hF;
            if (acc_q[11:8] == 4'd0) begin
                commit_bcd[11:8] = 4'hF;
                if (acc_q[7:4] == 4'd0) begin
                    commit_bcd[7:4] = 4'hF;
                end
            end
        end
    end
`else
    // Plain BCD, leading zeros kept.
    always_comb begin
        commit_bcd = acc_q;
    end
`endif

    // Arbitration / conversion / dwell state machine with registered outputs.
    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            bin_q      <= '0;
            acc_q      <= '0;
            iter_q     <= '0;
            ovf_pend_q <= 1'b0;
            src_pend_q <= '0;
            dwell_q    <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            bcd_q      <= '0;
            src_q      <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            grant_q <= '0;
            if (launch) begin
                grant_q    <= 4'(1) << sel_idx;
                ptr_q      <= sel_idx + 2'd1;
                bin_q      <= sel_val;
                acc_q      <= '0;
                iter_q     <= '0;
                ovf_pend_q <= sel_ovf;
                src_pend_q <= sel_idx;
                busy_q     <= 1'b1;
                state_q    <= CONVERT;
            end else begin
                case (state_q)
                    CONVERT: begin
                        if (iter_q == LAST_ITER) begin
                            bcd_q   <= commit_bcd;
                            src_q   <= src_pend_q;
                            ovf_q   <= ovf_pend_q;
                            valid_q <= 1'b1;
                            dwell_q <= '0;
                            state_q <= SHOW;
                        end else begin
                            acc_q  <= acc_d;
                            bin_q  <= {bin_q[14:0], 1'b0};
                            iter_q <= iter_q + 5'd1;
                        end
                    end
                    SHOW: begin
                        if (dwell_done) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            dwell_q <= dwell_q + DW'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign bcd       = bcd_q;
    assign src_id    = src_q;
    assign overflow  = ovf_q;
    assign bcd_valid = valid_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed self-checking bench for disp_arbiter (DWELL_CYCLES = 4).
module tb_disp_arbiter;

    localparam int unsigned DWELL = 4;

`ifdef DISP_LZB_EN
    localparam logic [15:0] EXP_7  = 16'hFFF7;
    localparam logic [15:0] EXP_0  = 16'hFFF0;
    localparam logic [15:0] EXP_42 = 16'hFF42;
`else
    localparam logic [15:0] EXP_7  = 16'h0007;
    localparam logic [15:0] EXP_0  = 16'h0000;
    localparam logic [15:0] EXP_42 = 16'h0042;
`endif

    logic        clk_100mhz = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] data_flat;
    logic [3:0]  grant;
    logic        busy;
    logic [15:0] bcd;
    logic [1:0]  src_id;
    logic        overflow;
    logic        bcd_valid;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    disp_arbiter #(.DWELL_CYCLES(DWELL)) dut (
        .clk_100mhz(clk_100mhz),
        .reset     (reset),
        .req       (req),
        .data_flat (data_flat),
        .grant     (grant),
        .busy      (busy),
        .bcd       (bcd),
        .src_id    (src_id),
        .overflow  (overflow),
        .bcd_valid (bcd_valid)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    always @(posedge clk_100mhz) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(negedge clk_100mhz);
    endtask

    // Poll for a grant, bounded; reports what was seen so the caller can judge it.
    task automatic wait_grant(input int limit, output bit found, output logic [3:0] g, output int t);
        found = 1'b0;
        g     = '0;
        t     = 0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk_100mhz);
            if (grant !== 4'b0000) begin
                found = 1'b1;
                g     = grant;
                t     = cyc;
            end
        end
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        req       = 4'b0001;
        data_flat = 64'h0;
        data_flat[15:0] = 16'd1234;
        step(3);
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b, expected 0000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL reset_bcd: got %h, expected 0000", bcd); end
        checks++; if (src_id !== 2'd0) begin errors++; $display("FAIL reset_src: got %0d, expected 0", src_id); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b, expected 0", overflow); end
        checks++; if (bcd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", bcd_valid); end
        req   = 4'b0000;
        reset = 1'b0;
        step(2);
        checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL idle_no_req: got grant=%b busy=%b, expected 0000/0", grant, busy); end
    endtask

    task automatic test_basic;
        bit found; logic [3:0] g; int t;
        data_flat[15:0] = 16'd1234;
        req = 4'b0001;
        wait_grant(10, found, g, t);
        checks++; if (!found || g !== 4'b0001) begin errors++; $display("FAIL basic_grant: got %b, expected 0001", g); end
        req = 4'b0000;
        step(1);
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL basic_grant_pulse: got %b, expected 0000", grant); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b, expected 1", busy); end
        step(15);
        checks++; if (bcd !== 16'h0000 || bcd_valid !== 1'b0) begin errors++; $display("FAIL basic_early: got bcd=%h valid=%b, expected 0000/0", bcd, bcd_valid); end
        step(1);
        checks++; if (bcd !== 16'h1234) begin errors++; $display("FAIL basic_bcd: got %h, expected 1234", bcd); end
        checks++; if (src_id !== 2'd0 || overflow !== 1'b0 || bcd_valid !== 1'b1) begin errors++; $display("FAIL basic_flags: got src=%0d ovf=%b valid=%b, expected 0/0/1", src_id, overflow, bcd_valid); end
        step(3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_dwell_busy: got %b, expected 1", busy); end
        step(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_dwell_end: got %b, expected 0", busy); end
    endtask

    task automatic test_overflow;
        bit found; logic [3:0] g; int t;
        data_flat[47:32] = 16'hFFFF;
        req = 4'b0100;
        wait_grant(10, found, g, t);
        checks++; if (!found || g !== 4'b0100) begin errors++; $display("FAIL ovf_grant: got %b, expected 0100", g); end
        req = 4'b0000;
        step(17);
        checks++; if (bcd !== 16'h9999) begin errors++; $display("FAIL ovf_bcd: got %h, expected 9999", bcd); end
        checks++; if (src_id !== 2'd2 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_flags: got src=%0d ovf=%b, expected 2/1", src_id, overflow); end
        step(5);
    endtask

    task automatic test_lzb;
        bit found; logic [3:0] g; int t;
        data_flat[15:0] = 16'd7;
        req = 4'b0001;
        wait_grant(10, found, g, t);
        checks++; if (!found || g !== 4'b0001) begin errors++; $display("FAIL lzb7_grant: got %b, expected 0001", g); end
        req = 4'b0000;
        step(17);
        checks++; if (bcd !== EXP_7 || overflow !== 1'b0) begin errors++; $display("FAIL lzb7_bcd: got %h ovf=%b, expected %h ovf=0", bcd, overflow, EXP_7); end
        step(5);
        data_flat[15:0] = 16'd0;
        req = 4'b0001;
        wait_grant(10, found, g, t);
        checks++; if (!found || g !== 4'b0001) begin errors++; $display("FAIL lzb0_grant: got %b, expected 0001", g); end
        req = 4'b0000;
        step(17);
        checks++; if (bcd !== EXP_0 || src_id !== 2'd0) begin errors++; $display("FAIL lzb0_bcd: got %h src=%0d, expected %h src=0", bcd, src_id, EXP_0); end
        step(5);
    endtask

    task automatic test_round_robin;
        bit found; logic [3:0] g; int t; int t_prev;
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        bit done;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        data_flat = 64'h0004_0003_0002_0001;
        req = 4'b1111;
        t_prev = 0;
        for (int i = 0; i < 5; i++) begin
            wait_grant(40, found, g, t);
            checks++; if (!found || g !== exp_g[i]) begin errors++; $display("FAIL rr_grant%0d: got %b, expected %b", i, g, exp_g[i]); end
            if (i > 0) begin
                checks++; if (t - t_prev != 21) begin errors++; $display("FAIL rr_spacing%0d: got %0d, expected 21", i, t - t_prev); end
            end
            t_prev = t;
            step(1);
            checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rr_pulse%0d: got %b, expected 0000", i, grant); end
        end
        req = 4'b0000;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            step(1);
            if (busy === 1'b0) done = 1'b1;
        end
        checks++; if (!done) begin errors++; $display("FAIL rr_idle: got busy=%b, expected 0 within 40 cycles", busy); end
    endtask

    task automatic test_reset_abort;
        bit found; logic [3:0] g; int t;
        data_flat = 64'h0;
        data_flat[15:0]  = 16'd1234;
        data_flat[63:48] = 16'd555;
        req = 4'b1000;
        wait_grant(10, found, g, t);
        checks++; if (!found || g !== 4'b1000) begin errors++; $display("FAIL abort_grant3: got %b, expected 1000", g); end
        req = 4'b1001;
        step(5);
        reset = 1'b1;
        step(1);
        checks++; if (bcd !== 16'h0000 || busy !== 1'b0 || bcd_valid !== 1'b0) begin errors++; $display("FAIL abort_reset: got bcd=%h busy=%b valid=%b, expected 0000/0/0", bcd, busy, bcd_valid); end
        step(1);
        reset = 1'b0;
        wait_grant(10, found, g, t);
        checks++; if (!found || g !== 4'b0001) begin errors++; $display("FAIL abort_first_grant: got %b, expected 0001", g); end
        req = 4'b0000;
        step(16);
        checks++; if (bcd !== 16'h0000 || bcd_valid !== 1'b0) begin errors++; $display("FAIL abort_no_commit: got bcd=%h valid=%b, expected 0000/0", bcd, bcd_valid); end
        step(1);
        checks++; if (bcd !== 16'h1234 || src_id !== 2'd0) begin errors++; $display("FAIL abort_next: got bcd=%h src=%0d, expected 1234/0", bcd, src_id); end
        step(5);
    endtask

    task automatic test_drop;
        bit found; logic [3:0] g; int t; int n_grants;
        data_flat[31:16] = 16'd42;
        req = 4'b0010;
        wait_grant(10, found, g, t);
        checks++; if (!found || g !== 4'b0010) begin errors++; $display("FAIL drop_grant: got %b, expected 0010", g); end
        step(17);
        checks++; if (bcd !== EXP_42 || src_id !== 2'd1) begin errors++; $display("FAIL drop_bcd: got %h src=%0d, expected %h src=1", bcd, src_id, EXP_42); end
        step(1);
        req = 4'b0000;
        step(2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_show_busy: got %b, expected 1", busy); end
        step(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy_fall: got %b, expected 0", busy); end
        n_grants = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (grant !== 4'b0000) n_grants++;
        end
        checks++; if (n_grants != 0) begin errors++; $display("FAIL drop_no_grant: got %0d grants, expected 0", n_grants); end
        checks++; if (bcd !== EXP_42) begin errors++; $display("FAIL drop_hold: got %h, expected %h", bcd, EXP_42); end
    endtask

    initial begin
        reset     = 1'b1;
        req       = 4'b0000;
        data_flat = 64'h0;
        test_reset();
        test_basic();
        test_overflow();
        test_lzb();
        test_round_robin();
        test_reset_abort();
        test_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
